ans_ht_preamble_seq: RTL and testbench

//  Sequences HT-STF and HT-LTF generators for one HT preamble per tx_start: arms each generator,

---
 rtl/ans_preamble_pkg.sv | 29 ++
 rtl/ans_ht_preamble_seq_if.sv | 12 +
 rtl/ans_preamble_skid.sv | 50 +++++
 rtl/ans_ht_preamble_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_ans_ht_preamble_seq.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ans_preamble_pkg.sv
// ans_preamble_pkg: shared types and constants for the HT preamble sequencer.
package ans_preamble_pkg;

    localparam int SYM_LEN = 80;   // samples per STF/LTF symbol
    localparam int MAX_LTF = 4;    // HT-LTF symbols per preamble, upper bound

    typedef logic [31:0] sample_t; // {I,Q}

    typedef enum logic [2:0] {
        IDLE,
        STF_ARM,
        STF_WAIT,
        STF_STREAM,
        LTF_ARM,
        LTF_WAIT,
        LTF_STREAM,
        DRAIN
    } state_t;

    // Requested LTF count folded into 1..MAX_LTF.
    function automatic logic [2:0] clamp_n_ltf(input logic [2:0] n);
        if (n == 3'd0)
            return 3'd1;
        if (n > 3'(MAX_LTF))
            return 3'(MAX_LTF);
        return n;
    endfunction

endpackage

// File: rtl/ans_ht_preamble_seq_if.sv
// ans_ht_preamble_seq_if: valid/ready sample stream towards the dot11 sample mux.
interface ans_ht_preamble_seq_if;
    import ans_preamble_pkg::*;

    sample_t sample;
    logic    valid;
    logic    ready;

    modport master (output sample, output valid, input ready);
    modport slave  (input sample, input valid, output ready);

endinterface

// File: rtl/ans_preamble_skid.sv
// ans_preamble_skid: 2-entry sample FIFO with occupancy count and synchronous flush.
module ans_preamble_skid
    import ans_preamble_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     push,
    input  sample_t  push_data,
    input  logic     pop,
    output sample_t  rd_data,
    output logic [1:0] cnt
);

    sample_t mem [2];
    logic    wr_ptr;
    logic    rd_ptr;
    logic    do_push;
    logic    do_pop;

    assign do_push = push && (cnt != 2'd2);
    assign do_pop  = pop  && (cnt != 2'd0);

    // Storage, pointers and occupancy; flush empties without touching storage.
    // NOTE: storage is reset as well, because rd_data feeds a top-level output that must read 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ans_ht_preamble_seq.sv
// ans_ht_preamble_seq: runs one HT preamble (1 STF symbol + 1..MAX_LTF LTF symbols) per tx_start,
// arming each generator, waiting for its started flag and streaming SYM_LEN samples per symbol
// through a small FIFO towards the sample mux.
// Optional feature: define ANS_PREAMBLE_COEFF_SHADOW_EN to buffer coefficient writes made while
// busy and apply them at the next accepted tx_start.
module ans_ht_preamble_seq
    import ans_preamble_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 512
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tx_start,
    input  logic          abort,
    input  logic [2:0]    n_ltf,
    input  logic [127:0]  coeff_in,
    input  logic          coeff_we,
    output logic          stf_letsgo,
    output logic          stf_givemeoutput,
    output logic [127:0]  stf_obf_coeff,
    input  sample_t       stf_sample,
    input  logic          stf_started,
    output logic          ltf_letsgo,
    output logic          ltf_givemeoutput,
    input  sample_t       ltf_sample,
    input  logic          ltf_started,
    output logic          gen_reset,
    ans_ht_preamble_seq_if.master out,
    output logic          busy,
    output logic          done,
    output logic          err_timeout
);

    localparam int TMR_W = $clog2(WAIT_TIMEOUT);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q;
    logic [6:0]       smp_cnt_q;
    logic [2:0]       ltf_idx_q;
    logic [2:0]       n_ltf_q;

    logic [1:0]       fifo_cnt;
    sample_t          fifo_rd;
    sample_t          push_data;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;

    logic             smp_clr;
    logic             ltf_sym_end;
    logic             tx_accept;
    logic             give_ok;
    logic             in_timed;
    logic             act_started;
    logic             timeout_hit;
    logic             sym_last;
    logic             more_ltf;

    // Generator may hand over a sample only if the FIFO can take it this cycle without overflowing.
    assign give_ok     = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && out.ready);
    assign in_timed    = (state_q == STF_WAIT) || (state_q == STF_STREAM) ||
                         (state_q == LTF_WAIT) || (state_q == LTF_STREAM);
    assign act_started = ((state_q == STF_WAIT) || (state_q == STF_STREAM)) ? stf_started : ltf_started;
    assign timeout_hit = (timer_q == TMR_W'(WAIT_TIMEOUT - 1));
    assign sym_last    = (smp_cnt_q == 7'(SYM_LEN - 1));
    assign more_ltf    = ((ltf_idx_q + 3'd1) < n_ltf_q);
    assign tx_accept   = (state_q == IDLE) && tx_start && !abort;

    assign busy      = (state_q != IDLE);
    assign out.valid = (fifo_cnt != 2'd0);
    assign out.sample = fifo_rd;
    assign fifo_pop  = out.valid && out.ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values;
    // the combinational block below uses blocking assignments because it computes in program order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, generator handshakes and event pulses; abort overrides everything.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d          = state_q;
        stf_letsgo       = 1'b0;
        ltf_letsgo       = 1'b0;
        stf_givemeoutput = 1'b0;
        ltf_givemeoutput = 1'b0;
        gen_reset        = 1'b0;
        err_timeout      = 1'b0;
        done             = 1'b0;
        fifo_push        = 1'b0;
        fifo_flush       = 1'b0;
        push_data        = stf_sample;
        smp_clr          = 1'b0;
        ltf_sym_end      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_start)
                    state_d = STF_ARM;
            end
            STF_ARM: begin
                stf_letsgo = 1'b1;
                state_d    = STF_WAIT;
            end
            STF_WAIT: begin
                if (stf_started) begin
                    state_d = STF_STREAM;
                    smp_clr = 1'b1;
                end
            end
            STF_STREAM: begin
                stf_givemeoutput = give_ok;
                if (stf_started && give_ok) begin
                    fifo_push = 1'b1;
                    if (sym_last)
                        state_d = LTF_ARM;
                end
            end
            LTF_ARM: begin
                ltf_letsgo = 1'b1;
                state_d    = LTF_WAIT;
            end
            LTF_WAIT: begin
                if (ltf_started) begin
                    state_d = LTF_STREAM;
                    smp_clr = 1'b1;
                end
            end
            LTF_STREAM: begin
                ltf_givemeoutput = give_ok;
                push_data        = ltf_sample;
                if (ltf_started && give_ok) begin
                    fifo_push = 1'b1;
                    if (sym_last) begin
                        ltf_sym_end = 1'b1;
                        state_d     = more_ltf ? LTF_ARM : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_cnt == 2'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Started missing for too long, either while waiting or after dropping mid-symbol.
        if (in_timed && !act_started && timeout_hit) begin
            err_timeout = 1'b1;
            gen_reset   = 1'b1;
            fifo_flush  = 1'b1;
            state_d     = IDLE;
        end

        if (abort) begin
            state_d          = IDLE;
            stf_letsgo       = 1'b0;
            ltf_letsgo       = 1'b0;
            stf_givemeoutput = 1'b0;
            ltf_givemeoutput = 1'b0;
            err_timeout      = 1'b0;
            done             = 1'b0;
            fifo_push        = 1'b0;
            smp_clr          = 1'b0;
            ltf_sym_end      = 1'b0;
            fifo_flush       = 1'b1;
            gen_reset        = (state_q != IDLE);
        end
    end

    // Started watchdog: runs while the active generator is not started, restarts whenever it is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer_q <= '0;
        else if (in_timed && !act_started && (state_d == state_q))
            timer_q <= timer_q + 1'b1;
        else
            timer_q <= '0;
    end

    // Per-symbol sample counter and LTF symbol bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_cnt_q <= '0;
            ltf_idx_q <= '0;
            n_ltf_q   <= '0;
        end else begin
            if (smp_clr)
                smp_cnt_q <= '0;
            else if (fifo_push)
                smp_cnt_q <= smp_cnt_q + 7'd1;

            if (tx_accept) begin
                ltf_idx_q <= '0;
                n_ltf_q   <= clamp_n_ltf(n_ltf);
            end else if (ltf_sym_end) begin
                ltf_idx_q <= ltf_idx_q + 3'd1;
            end
        end
    end

`ifdef ANS_PREAMBLE_COEFF_SHADOW_EN
    logic [127:0] shadow_q;

    // Shadow tracks every write; the live register takes it at the next accepted tx_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q      <= '0;
            stf_obf_coeff <= '0;
        end else begin
            if (coeff_we)
                shadow_q <= coeff_in;
            if (tx_accept)
                stf_obf_coeff <= coeff_we ? coeff_in : shadow_q;
            else if (coeff_we && !busy)
                stf_obf_coeff <= coeff_in;
        end
    end
`else
    // Coefficients change only between preambles; writes while busy are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stf_obf_coeff <= '0;
        else if (coeff_we && !busy)
            stf_obf_coeff <= coeff_in;
    end
`endif

    ans_preamble_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .rd_data   (fifo_rd),
        .cnt       (fifo_cnt)
    );

endmodule

// File: tb/tb_ans_ht_preamble_seq.sv
// tb_ans_ht_preamble_seq: directed bench for the HT preamble sequencer with behavioural STF/LTF
// generators and a stream scoreboard.
module tb_ans_ht_preamble_seq;
    import ans_preamble_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tx_start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    n_ltf = 3'd1;
    logic [127:0]  coeff_in = '0;
    logic          coeff_we = 1'b0;
    logic          stf_letsgo, stf_give, ltf_letsgo, ltf_give;
    logic [127:0]  stf_obf_coeff;
    sample_t       stf_sample, ltf_sample;
    logic          stf_started, ltf_started;
    logic          gen_reset, busy, done, err_timeout;

    ans_ht_preamble_seq_if out_if ();

    always #5 clk = ~clk;

    ans_ht_preamble_seq dut (
        .clk              (clk),
        .reset            (reset),
        .tx_start         (tx_start),
        .abort            (abort),
        .n_ltf            (n_ltf),
        .coeff_in         (coeff_in),
        .coeff_we         (coeff_we),
        .stf_letsgo       (stf_letsgo),
        .stf_givemeoutput (stf_give),
        .stf_obf_coeff    (stf_obf_coeff),
        .stf_sample       (stf_sample),
        .stf_started      (stf_started),
        .ltf_letsgo       (ltf_letsgo),
        .ltf_givemeoutput (ltf_give),
        .ltf_sample       (ltf_sample),
        .ltf_started      (ltf_started),
        .gen_reset        (gen_reset),
        .out              (out_if),
        .busy             (busy),
        .done             (done),
        .err_timeout      (err_timeout)
    );

    // ---------------- behavioural generators ----------------
    int  gen_delay = 20;
    bit  stf_never = 1'b0;

    int  stf_wait, ltf_wait;
    bit  stf_arm, ltf_arm;
    logic [15:0] stf_idx, ltf_idx;
    logic [7:0]  ltf_sym, ltf_nsym;

    assign stf_sample = {8'h53, 8'h00, stf_idx};
    assign ltf_sample = {8'h4C, ltf_sym, ltf_idx};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stf_started <= 1'b0; stf_arm <= 1'b0; stf_idx <= '0; stf_wait <= 0;
        end else if (gen_reset) begin
            stf_started <= 1'b0; stf_arm <= 1'b0;
        end else begin
            if (stf_letsgo) begin
                stf_arm <= 1'b1; stf_started <= 1'b0; stf_idx <= '0; stf_wait <= gen_delay;
            end else if (stf_arm && !stf_started) begin
                if (stf_wait <= 1 && !stf_never) stf_started <= 1'b1;
                else stf_wait <= stf_wait - 1;
            end
            if (stf_started && stf_give) stf_idx <= stf_idx + 16'd1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ltf_started <= 1'b0; ltf_arm <= 1'b0; ltf_idx <= '0; ltf_wait <= 0;
            ltf_sym <= '0; ltf_nsym <= '0;
        end else if (gen_reset) begin
            ltf_started <= 1'b0; ltf_arm <= 1'b0;
        end else begin
            if (stf_letsgo) ltf_nsym <= '0;
            if (ltf_letsgo) begin
                ltf_arm <= 1'b1; ltf_started <= 1'b0; ltf_idx <= '0; ltf_wait <= gen_delay;
                ltf_sym <= ltf_nsym; ltf_nsym <= ltf_nsym + 8'd1;
            end else if (ltf_arm && !ltf_started) begin
                if (ltf_wait <= 1) ltf_started <= 1'b1;
                else ltf_wait <= ltf_wait - 1;
            end
            if (ltf_started && ltf_give) ltf_idx <= ltf_idx + 16'd1;
        end
    end

    // ---------------- stream monitor / scoreboard ----------------
    function automatic sample_t exp_sample(input int k);
        int j;
        if (k < SYM_LEN)
            return {8'h53, 8'h00, 16'(k)};
        j = k - SYM_LEN;
        return {8'h4C, 8'(j / SYM_LEN), 16'(j % SYM_LEN)};
    endfunction

    int ncyc = 0, rx_cnt = 0, seq_err = 0, valid_cyc = 0;
    int done_cnt = 0, err_cnt = 0, grst_cnt = 0;
    int letsgo_cyc = 0, acc_cyc = 0, done_cyc = 0, err_cyc = 0, grst_cyc = 0;

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (stf_letsgo) begin
            rx_cnt     <= 0;
            letsgo_cyc <= ncyc;
        end
        if (out_if.valid) valid_cyc <= valid_cyc + 1;
        if (out_if.valid && out_if.ready) begin
            if (out_if.sample !== exp_sample(rx_cnt)) seq_err <= seq_err + 1;
            rx_cnt  <= rx_cnt + 1;
            acc_cyc <= ncyc;
        end
        if (done)        begin done_cnt <= done_cnt + 1; done_cyc <= ncyc; end
        if (err_timeout) begin err_cnt  <= err_cnt + 1;  err_cyc  <= ncyc; end
        if (gen_reset)   begin grst_cnt <= grst_cnt + 1; grst_cyc <= ncyc; end
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [2:0] n);
        n_ltf    = n;
        tx_start = 1'b1;
        step(1);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit toggle, output bit ok);
        int start;
        start = done_cnt;
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            step(1);
            if (toggle) out_if.ready = ~out_if.ready;
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    int n_tab [3]   = '{0, 7, 2};
    int len_tab [3] = '{160, 400, 240};

    initial begin
        bit ok;
        int v0, g0, e0;

        out_if.ready = 1'b1;
        step(2);
        // Reset state
        check("rst_busy",   128'(busy), 128'd0);
        check("rst_valid",  128'(out_if.valid), 128'd0);
        check("rst_sample", 128'(out_if.sample), 128'd0);
        check("rst_coeff",  stf_obf_coeff, 128'd0);
        check("rst_letsgo", 128'({stf_letsgo, ltf_letsgo, stf_give, ltf_give}), 128'd0);
        check("rst_pulses", 128'({gen_reset, done, err_timeout}), 128'd0);
        reset = 1'b0;
        step(2);

        // 1: single LTF, ready held high
        start_run(3'd1);
        check("t1_busy", 128'(busy), 128'd1);
        wait_done(2000, 1'b0, ok);
        check("t1_done_seen", 128'(ok), 128'd1);
        check("t1_count", 128'(rx_cnt), 128'd160);
        check("t1_seq_err", 128'(seq_err), 128'd0);
        check("t1_done_lat", 128'(done_cyc - acc_cyc), 128'd1);
        check("t1_idle", 128'({busy, out_if.valid}), 128'd0);

        // 2: ready toggling every cycle
        start_run(3'd1);
        wait_done(3000, 1'b1, ok);
        out_if.ready = 1'b1;
        check("t2_done_seen", 128'(ok), 128'd1);
        check("t2_count", 128'(rx_cnt), 128'd160);
        check("t2_seq_err", 128'(seq_err), 128'd0);
        check("t2_done_lat", 128'(done_cyc - acc_cyc), 128'd1);

        // 3: STF never starts
        stf_never = 1'b1;
        v0 = valid_cyc;
        e0 = err_cnt;
        g0 = grst_cnt;
        start_run(3'd1);
        ok = 1'b0;
        for (int c = 0; c < 700; c++) begin
            step(1);
            if (err_cnt != e0) begin ok = 1'b1; break; end
        end
        check("t3_err_seen", 128'(ok), 128'd1);
        check("t3_err_lat", 128'(err_cyc - letsgo_cyc), 128'd512);
        check("t3_grst_cnt", 128'(grst_cnt - g0), 128'd1);
        check("t3_grst_cyc", 128'(grst_cyc), 128'(err_cyc));
        check("t3_busy", 128'(busy), 128'd0);
        check("t3_no_valid", 128'(valid_cyc - v0), 128'd0);
        stf_never = 1'b0;
        step(2);

        // 4: LTF count clamping
        for (int i = 0; i < 3; i++) begin
            start_run(3'(n_tab[i]));
            wait_done(3000, 1'b0, ok);
            check($sformatf("t4_done_n%0d", n_tab[i]), 128'(ok), 128'd1);
            check($sformatf("t4_count_n%0d", n_tab[i]), 128'(rx_cnt), 128'(len_tab[i]));
        end
        check("t4_seq_err", 128'(seq_err), 128'd0);

        // 5: abort at STF sample 40, then a clean run
        start_run(3'd1);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (rx_cnt >= 40) begin ok = 1'b1; break; end
            step(1);
        end
        check("t5_reach40", 128'(ok), 128'd1);
        g0 = grst_cnt;
        abort = 1'b1;
        #1;
        check("t5_grst", 128'(gen_reset), 128'd1);
        step(1);
        abort = 1'b0;
        #1;
        check("t5_busy", 128'(busy), 128'd0);
        check("t5_flushed", 128'(out_if.valid), 128'd0);
        check("t5_grst_once", 128'(grst_cnt - g0), 128'd1);
        start_run(3'd1);
        wait_done(2000, 1'b0, ok);
        check("t5_rerun_done", 128'(ok), 128'd1);
        check("t5_rerun_count", 128'(rx_cnt), 128'd160);
        check("t5_seq_err", 128'(seq_err), 128'd0);

        // 6: coefficient register behaviour, then reset mid-run
        coeff_in = {4{32'h1111_1111}};
        coeff_we = 1'b1;
        step(1);
        coeff_we = 1'b0;
        check("t6_idle_we", stf_obf_coeff, {4{32'h1111_1111}});
        start_run(3'd1);
        step(3);
        coeff_in = {4{32'hA5A5_A5A5}};
        coeff_we = 1'b1;
        step(1);
        coeff_we = 1'b0;
        check("t6_busy_stable", stf_obf_coeff, {4{32'h1111_1111}});
        wait_done(2000, 1'b0, ok);
        check("t6_done_seen", 128'(ok), 128'd1);
        check("t6_after_run", stf_obf_coeff, {4{32'h1111_1111}});
        start_run(3'd1);
`ifdef ANS_PREAMBLE_COEFF_SHADOW_EN
        check("t6_next_run", stf_obf_coeff, {4{32'hA5A5_A5A5}});
`else
        check("t6_next_run", stf_obf_coeff, {4{32'h1111_1111}});
`endif
        step(60);
        reset = 1'b1;
        #1;
        check("t6_rst_busy", 128'(busy), 128'd0);
        check("t6_rst_valid", 128'({out_if.valid, out_if.sample}), 128'd0);
        check("t6_rst_coeff", stf_obf_coeff, 128'd0);
        check("t6_rst_gen", 128'({stf_letsgo, ltf_letsgo, stf_give, ltf_give}), 128'd0);
        check("t6_rst_pulses", 128'({gen_reset, done, err_timeout}), 128'd0);
        step(2);
        reset = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
